pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline sequencing unit for the 5-stage RV32 core. It replaces the hard-wired "no stall / no forward" ties in ID with real hazard detection, EX-stage forwarding selection, ID-branch flush control and a multi-cycle data-memory freeze. It also provides a start FSM and performance counters.

It keeps its own shadow copy of the EX/MEM/WB control fields (valid, rd, RegWrite, MemRead, MemAccess), so it needs no taps into the datapath pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register-address width (register 0 is hard zero).
- MEM_LAT, 1, data-memory access cycles, legal 1..8.
- CNT_W, 32, width of performance counters.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  leaves IDLE when high.
- id_valid_i  in  1  ID holds a real instruction (not flush NOP).
- id_rs1_i, id_rs2_i  in  REG_AW each  ID source registers.
- id_use_rs1_i, id_use_rs2_i  in  1 each  source actually read.
- id_rd_i  in  REG_AW  ID destination.
- id_regwrite_i, id_memread_i, id_memwrite_i, id_branch_i  in  1 each  decoded controls.
- id_br_eq_i  in  1  ID comparator result (rs1==rs2).
- pc_write_o  out  1  PC may update.
- pc_sel_o  out  1  1 = branch target, 0 = PC+4.
- ifid_stall_o  out  1  IF/ID holds.
- ifid_flush_o  out  1  IF/ID loads NOP.
- idex_bubble_o  out  1  ID/EX loads all-zero controls.
- freeze_o  out  1  ID/EX, EX/MEM, MEM/WB and PC all hold.
- fwd_a_o, fwd_b_o  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

## Operation
- FSM:
  - IDLE (reset state) → RUN when start_i is high.
  - RUN → MWAIT when a memory op enters MEM and MEM_LAT>1; the wait counter loads MEM_LAT-1.
  - MWAIT decrements the counter and returns to RUN on the cycle it reaches 0.
  - RUN/MWAIT never return to IDLE except by reset.
- IDLE outputs: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, freeze_o=0, pc_sel_o=0, ifid_flush_o=0.
- MWAIT: freeze_o=1, pc_write_o=0, ifid_stall_o=1, idex_bubble_o=0, ifid_flush_o=0. Shadow stages hold.
- A match means: stage valid, RegWrite=1, rd≠0, and rd equals an ID source whose use bit is set.
- Hazard stall (RUN, evaluated in ID) sets pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. It triggers on any of:
  - load-use: EX MemRead match;
  - branch: id_branch_i with an EX match, or a MEM match where MEM is a load;
  - additional cases depending on forwarding mode (see Configuration).
- Flush: RUN, no stall, id_valid_i, id_branch_i, id_br_eq_i → pc_sel_o=1, ifid_flush_o=1, pc_write_o=1.
- Priority: freeze > hazard stall > flush > normal advance. A stalled branch never flushes.
- Shadow advance (RUN, no freeze):
  - EX ← ID fields, or zeros when idex_bubble_o is set;
  - MEM ← EX;
  - WB ← MEM.
- Forwarding (EX operands):
  - fwd_a_o=10 if the MEM stage matches EX rs; else 01 if the WB stage matches; else 00. Same rule for fwd_b_o.
  - MEM priority over WB; rd=0 never forwards.
  - The shadow EX stage stores rs1/rs2 for this comparison.
- Counters:
  - cycle_cnt_o increments every non-IDLE cycle.
  - stall_cnt_o increments every cycle with a hazard stall or freeze.
  - flush_cnt_o increments per flush.
  - All counters wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from inputs and registered state, valid in the same cycle.
- Shadow stages, FSM and counters update on the rising clock edge.
- Load-use costs 1 bubble.
- A taken branch costs 1 flushed slot.
- Each memory op adds MEM_LAT-1 freeze cycles, starting the cycle after it enters MEM.
- Reset (asynchronous, at any time including MWAIT):
  - FSM → IDLE, wait counter 0;
  - all shadow valid bits 0;
  - counters 0;
  - outputs take their IDLE values immediately.
- MEM_LAT=1: MWAIT is unreachable and freeze_o stays 0.

## Configuration
- PIPE_HAZARD_CTRL_FWD_EN defined: forwarding as described above.
- Undefined:
  - fwd_a_o and fwd_b_o are tied to 00;
  - every ID instruction with a source that matches an EX, MEM or WB writer stalls until that writer leaves WB;
  - the regfile is read-before-write.

## Test plan
- Reset low mid-MWAIT with MEM_LAT=3 → freeze_o=0 and pc_write_o=0 immediately; counters read 0.
- After start, `lw x5,0(x0)` followed by `add x6,x5,x5` (FWD_EN) → exactly 1 cycle with idex_bubble_o=1; when the add reaches EX, fwd_a_o=fwd_b_o=01.
- `add x1,..` followed by `sub x2,x1,x1` (FWD_EN) → no stall; fwd_a_o=fwd_b_o=10 in the sub's EX cycle.
- Same pair with FWD_EN undefined → 3 stall cycles; fwd_a_o and fwd_b_o stay 00.
- `beq` taken with no hazard → pc_sel_o=1 and ifid_flush_o=1 for 1 cycle; flush_cnt_o=1.
- `beq` with rs1 written by the EX-stage add → 1 stall cycle with no flush, then the flush; with a load, 2 stall cycles.
- MEM_LAT=4 with a sw → freeze_o high for 3 cycles; stall_cnt_o increases by 3.
- Writer with rd=x0 → no forward and no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, EX forwarding select, ID-branch flush,
// multi-cycle data-memory freeze, start FSM and performance counters for the
// 5-stage RV32 core. Keeps a private shadow of the EX/MEM/WB control fields.
// Optional feature macro: PIPE_HAZARD_CTRL_FWD_EN (defined = forwarding on;
// undefined = forward selects tied to 00 and any in-flight writer stalls ID).
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              id_memwrite_i,
   input  logic              id_branch_i,
   input  logic              id_br_eq_i,
   output logic              pc_write_o,
   output logic              pc_sel_o,
   output logic              ifid_stall_o,
   output logic              ifid_flush_o,
   output logic              idex_bubble_o,
   output logic              freeze_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_MWAIT = 2'd2} state_t;

   localparam logic [2:0] LP_WAIT_INIT = 3'(MEM_LAT - 1);
   localparam logic       LP_MULTI     = (MEM_LAT > 1) ? 1'b1 : 1'b0;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_wait, w_wait_nxt;
   logic              w_stall, w_flush;

   // shadow pipeline control fields
   logic              r_ex_valid, r_ex_rw, r_ex_mr, r_ex_ma;
   logic [REG_AW-1:0] r_ex_rd;
   logic              r_mem_valid, r_mem_rw, r_mem_mr;
   logic [REG_AW-1:0] r_mem_rd;
   logic              r_wb_valid, r_wb_rw;
   logic [REG_AW-1:0] r_wb_rd;

   logic [CNT_W-1:0]  r_cycle_cnt, r_stall_cnt, r_flush_cnt;

   logic              w_ex_match, w_mem_match, w_wb_match;
   logic              w_load_use, w_br_haz, w_extra, w_hazard;

   // A writer matches a source when it is live, writes, targets a non-zero
   // register and that register is actually read.
   function automatic logic f_match(input logic              valid,
                                    input logic              rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs,
                                    input logic              use_rs);
      return valid & rw & use_rs & (rd != {REG_AW{1'b0}}) & (rd == rs);
   endfunction

   assign w_ex_match  = f_match(r_ex_valid, r_ex_rw, r_ex_rd, id_rs1_i, id_use_rs1_i)
                      | f_match(r_ex_valid, r_ex_rw, r_ex_rd, id_rs2_i, id_use_rs2_i);
   assign w_mem_match = f_match(r_mem_valid, r_mem_rw, r_mem_rd, id_rs1_i, id_use_rs1_i)
                      | f_match(r_mem_valid, r_mem_rw, r_mem_rd, id_rs2_i, id_use_rs2_i);
   assign w_wb_match  = f_match(r_wb_valid, r_wb_rw, r_wb_rd, id_rs1_i, id_use_rs1_i)
                      | f_match(r_wb_valid, r_wb_rw, r_wb_rd, id_rs2_i, id_use_rs2_i);

   assign w_load_use = w_ex_match & r_ex_mr;
   // The ID comparator can take a MEM-stage ALU result but not a MEM-stage load.
   assign w_br_haz   = id_branch_i & (w_ex_match | (w_mem_match & r_mem_mr));
`ifdef PIPE_HAZARD_CTRL_FWD_EN
   assign w_extra    = 1'b0;
`else
   // Without forwarding the regfile is the only source: wait until the writer retires.
   assign w_extra    = w_ex_match | w_mem_match | w_wb_match;
`endif
   assign w_hazard   = id_valid_i & (w_load_use | w_br_haz | w_extra);

   // FSM state and memory-wait counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_wait  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
      end
   end

   // next state and control outputs; priority freeze > stall > flush > advance
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait;
      w_stall       = 1'b0;
      w_flush       = 1'b0;
      pc_write_o    = 1'b0;
      pc_sel_o      = 1'b0;
      ifid_stall_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      freeze_o      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
            if (start_i) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_hazard) begin
               w_stall       = 1'b1;
               ifid_stall_o  = 1'b1;
               idex_bubble_o = 1'b1;
            end else if (id_valid_i && id_branch_i && id_br_eq_i) begin
               w_flush      = 1'b1;
               pc_write_o   = 1'b1;
               pc_sel_o     = 1'b1;
               ifid_flush_o = 1'b1;
            end else begin
               pc_write_o = 1'b1;
            end
            // the EX memory op moves into MEM on this edge
            if (LP_MULTI && r_ex_valid && r_ex_ma) begin
               w_state_nxt = ST_MWAIT;
               w_wait_nxt  = LP_WAIT_INIT;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_MWAIT: begin
            freeze_o     = 1'b1;
            ifid_stall_o = 1'b1;
            if (r_wait <= 3'd1) begin
               w_wait_nxt  = 3'd0;
               w_state_nxt = ST_RUN;
            end else begin
               w_wait_nxt  = r_wait - 3'd1;
               w_state_nxt = ST_MWAIT;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_wait_nxt    = 3'd0;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
         end
      endcase
   end

`ifdef PIPE_HAZARD_CTRL_FWD_EN
   logic              r_ex_u1, r_ex_u2;
   logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2;

   // EX source fields kept only for the forwarding compare
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ex_u1  <= 1'b0;
         r_ex_u2  <= 1'b0;
         r_ex_rs1 <= {REG_AW{1'b0}};
         r_ex_rs2 <= {REG_AW{1'b0}};
      end else if (r_state == ST_RUN) begin
         r_ex_u1  <= id_use_rs1_i & ~w_stall;
         r_ex_u2  <= id_use_rs2_i & ~w_stall;
         r_ex_rs1 <= w_stall ? {REG_AW{1'b0}} : id_rs1_i;
         r_ex_rs2 <= w_stall ? {REG_AW{1'b0}} : id_rs2_i;
      end else begin
         r_ex_u1  <= r_ex_u1;
         r_ex_u2  <= r_ex_u2;
         r_ex_rs1 <= r_ex_rs1;
         r_ex_rs2 <= r_ex_rs2;
      end
   end

   // EX operand select: youngest writer (MEM) wins over WB
   always_comb begin
      fwd_a_o = 2'b00;
      fwd_b_o = 2'b00;
      if (r_ex_valid && f_match(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rs1, r_ex_u1)) begin
         fwd_a_o = 2'b10;
      end else if (r_ex_valid && f_match(r_wb_valid, r_wb_rw, r_wb_rd, r_ex_rs1, r_ex_u1)) begin
         fwd_a_o = 2'b01;
      end else begin
         fwd_a_o = 2'b00;
      end
      if (r_ex_valid && f_match(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rs2, r_ex_u2)) begin
         fwd_b_o = 2'b10;
      end else if (r_ex_valid && f_match(r_wb_valid, r_wb_rw, r_wb_rd, r_ex_rs2, r_ex_u2)) begin
         fwd_b_o = 2'b01;
      end else begin
         fwd_b_o = 2'b00;
      end
   end
`else
   assign fwd_a_o = 2'b00;
   assign fwd_b_o = 2'b00;
`endif

   // shadow EX/MEM/WB advance; held in IDLE and during the memory freeze
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ex_valid  <= 1'b0;
         r_ex_rw     <= 1'b0;
         r_ex_mr     <= 1'b0;
         r_ex_ma     <= 1'b0;
         r_ex_rd     <= {REG_AW{1'b0}};
         r_mem_valid <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_mr    <= 1'b0;
         r_mem_rd    <= {REG_AW{1'b0}};
         r_wb_valid  <= 1'b0;
         r_wb_rw     <= 1'b0;
         r_wb_rd     <= {REG_AW{1'b0}};
      end else if (r_state == ST_RUN) begin
         r_ex_valid  <= id_valid_i & ~w_stall;
         r_ex_rw     <= id_regwrite_i & ~w_stall;
         r_ex_mr     <= id_memread_i & ~w_stall;
         r_ex_ma     <= (id_memread_i | id_memwrite_i) & ~w_stall;
         r_ex_rd     <= w_stall ? {REG_AW{1'b0}} : id_rd_i;
         r_mem_valid <= r_ex_valid;
         r_mem_rw    <= r_ex_rw;
         r_mem_mr    <= r_ex_mr;
         r_mem_rd    <= r_ex_rd;
         r_wb_valid  <= r_mem_valid;
         r_wb_rw     <= r_mem_rw;
         r_wb_rd     <= r_mem_rd;
      end else begin
         r_ex_valid  <= r_ex_valid;
         r_mem_valid <= r_mem_valid;
         r_wb_valid  <= r_wb_valid;
      end
   end

   // performance counters, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cycle_cnt <= {CNT_W{1'b0}};
         r_stall_cnt <= {CNT_W{1'b0}};
         r_flush_cnt <= {CNT_W{1'b0}};
      end else begin
         if (r_state != ST_IDLE) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         else                    r_cycle_cnt <= r_cycle_cnt;
         if (w_stall || freeze_o) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         else                     r_stall_cnt <= r_stall_cnt;
         if (w_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         else         r_flush_cnt <= r_flush_cnt;
      end
   end

   assign cycle_cnt_o = r_cycle_cnt;
   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_LAT=4). Expected control vectors
// are queued when each ID instruction is driven and compared mid-cycle.
module tb_pipe_hazard_ctrl;
   localparam int LP_AW  = 5;
   localparam int LP_LAT = 4;
   localparam int LP_CW  = 32;

   // {pc_write, pc_sel, ifid_stall, ifid_flush, idex_bubble, freeze, fwd_a, fwd_b}
   localparam logic [9:0] E_NORM  = 10'h200;
   localparam logic [9:0] E_STALL = 10'h0A0;
   localparam logic [9:0] E_FRZ   = 10'h090;
   localparam logic [9:0] E_FLUSH = 10'h340;
   localparam logic [9:0] E_IDLE  = 10'h0A0;

   logic clk, rst_ni, start_i, id_valid_i, id_use_rs1_i, id_use_rs2_i;
   logic [LP_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
   logic id_regwrite_i, id_memread_i, id_memwrite_i, id_branch_i, id_br_eq_i;
   logic pc_write_o, pc_sel_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, freeze_o;
   logic [1:0] fwd_a_o, fwd_b_o;
   logic [LP_CW-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;
   logic [9:0] w_obs;

   logic [9:0] exp_q[$];
   int n_pass, n_total, exp_cyc, exp_stl, exp_fls;
   bit started;

   pipe_hazard_ctrl #(.REG_AW(LP_AW), .MEM_LAT(LP_LAT), .CNT_W(LP_CW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i),
      .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
      .id_branch_i(id_branch_i), .id_br_eq_i(id_br_eq_i), .pc_write_o(pc_write_o),
      .pc_sel_o(pc_sel_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
      .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o), .fwd_a_o(fwd_a_o),
      .fwd_b_o(fwd_b_o), .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o),
      .flush_cnt_o(flush_cnt_o));

   assign w_obs = {pc_write_o, pc_sel_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
                   freeze_o, fwd_a_o, fwd_b_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic ua, input logic ub, input logic [4:0] d,
                         input logic rw, input logic mr, input logic mw,
                         input logic br, input logic eq);
      id_valid_i = v;  id_rs1_i = a; id_rs2_i = b; id_use_rs1_i = ua; id_use_rs2_i = ub;
      id_rd_i = d; id_regwrite_i = rw; id_memread_i = mr; id_memwrite_i = mw;
      id_branch_i = br; id_br_eq_i = eq;
   endtask

   task automatic nop_id();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // one clock: queue expectation, compare on the falling edge, advance
   task automatic cyc(input string tag, input logic [9:0] exp);
      exp_q.push_back(exp);
      if (started) begin
         exp_cyc++;
         if (exp[7]) exp_stl++;
         if (exp[6]) exp_fls++;
      end
      @(negedge clk);
      chk(tag, {22'd0, w_obs}, {22'd0, exp_q.pop_front()});
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass = 0; n_total = 0; exp_cyc = 0; exp_stl = 0; exp_fls = 0; started = 1'b0;
      rst_ni = 1'b0; start_i = 1'b0;
      nop_id();
      #2;
      chk("rst_outputs", {22'd0, w_obs}, {22'd0, E_IDLE});
      chk("rst_cycle_cnt", cycle_cnt_o, 32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      cyc("idle_hold", E_IDLE);
      start_i = 1'b1;
      cyc("idle_start", E_IDLE);
      start_i = 1'b0;
      started = 1'b1;
      chk("cycle_cnt_start", cycle_cnt_o, 32'd0);

      // lw x5,0(x0) ; add x6,x5,x5
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("lu_lw", E_NORM);
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("lu_stall", E_STALL);
      for (int i = 0; i < 3; i++) cyc("lu_freeze", E_FRZ);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
      cyc("lu_add", E_NORM);
      nop_id();
      cyc("lu_fwd_wb", E_NORM | 10'h005);
`else
      cyc("lu_stall_mem", E_STALL);
      cyc("lu_stall_wb", E_STALL);
      cyc("lu_add", E_NORM);
      nop_id();
      cyc("lu_nofwd", E_NORM);
`endif

      // add x1,x2,x3 ; sub x2,x1,x1
      set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("as_add", E_NORM);
      set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
      cyc("as_sub", E_NORM);
      nop_id();
      cyc("as_fwd_mem", E_NORM | 10'h00A);
`else
      for (int i = 0; i < 3; i++) cyc("as_stall", E_STALL);
      cyc("as_sub", E_NORM);
      nop_id();
      cyc("as_nofwd", E_NORM);
`endif

      // beq x3,x4 taken, no hazard
      set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("br_flush", E_FLUSH);
      nop_id();
      cyc("br_after", E_NORM);
      chk("flush_cnt_one", flush_cnt_o, 32'(exp_fls));

      // add x8 ; beq x8,x0 taken
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("ba_add", E_NORM);
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("ba_stall", E_STALL);
`ifdef PIPE_HAZARD_CTRL_FWD_EN
      cyc("ba_flush", E_FLUSH);
      nop_id();
      cyc("ba_nop", E_NORM | 10'h004);
`else
      cyc("ba_stall_mem", E_STALL);
      cyc("ba_stall_wb", E_STALL);
      cyc("ba_flush", E_FLUSH);
      nop_id();
      cyc("ba_nop", E_NORM);
`endif

      // lw x7 ; beq x7,x0 taken
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("bl_lw", E_NORM);
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("bl_stall_ex", E_STALL);
      for (int i = 0; i < 3; i++) cyc("bl_freeze", E_FRZ);
      cyc("bl_stall_mem", E_STALL);
`ifndef PIPE_HAZARD_CTRL_FWD_EN
      cyc("bl_stall_wb", E_STALL);
`endif
      cyc("bl_flush", E_FLUSH);
      nop_id();
      cyc("bl_nop", E_NORM);

      // sw x9,0(x10): three freeze cycles
      set_id(1'b1, 5'd10, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("sw_id", E_NORM);
      nop_id();
      cyc("sw_ex", E_NORM);
      for (int i = 0; i < 3; i++) cyc("sw_freeze", E_FRZ);
      cyc("sw_done", E_NORM);
      chk("stall_cnt_sw", stall_cnt_o, 32'(exp_stl));

      // add x0,x11,x12 ; sub x13,x0,x0 : rd=x0 never stalls or forwards
      set_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("z_add", E_NORM);
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("z_sub", E_NORM);
      nop_id();
      cyc("z_nofwd", E_NORM);
      chk("cycle_cnt", cycle_cnt_o, 32'(exp_cyc));
      chk("stall_cnt", stall_cnt_o, 32'(exp_stl));
      chk("flush_cnt", flush_cnt_o, 32'(exp_fls));

      // reset asserted in the middle of a memory wait
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("rs_sw", E_NORM);
      nop_id();
      cyc("rs_nop", E_NORM);
      cyc("rs_freeze", E_FRZ);
      #2;
      rst_ni = 1'b0;
      #1;
      exp_q.push_back(E_IDLE);
      chk("rst_mwait_out", {22'd0, w_obs}, {22'd0, exp_q.pop_front()});
      chk("rst_mwait_cycle", cycle_cnt_o, 32'd0);
      chk("rst_mwait_stall", stall_cnt_o, 32'd0);
      chk("rst_mwait_flush", flush_cnt_o, 32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      started = 1'b0;
      cyc("post_rst_idle", E_IDLE);
      chk("post_rst_cycle", cycle_cnt_o, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
